rf_writeback_arbiter: RTL and testbench

Shares the single register-file write port (wen/waddr/wdata, 32 x 32-bit, x0 hardwired to zero) among N writeback requesters (ALU, LSU, CSR) using round-robin arbitration with a valid/ready handshake. It also keeps a per-register busy scoreboard. Issue reserves a destination register, and the matching writeback clears it. The scoreboard feeds RAW/WAW hazard signals back to decode. It sits between the execute-stage units and the register file write port.

---
 rtl/rf_writeback_arbiter_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 59 +++++
 rtl/rf_writeback_arbiter.sv | 95 +++++++++
 tb/tb_rf_writeback_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
// Geometry, the x0 index and the requester slot numbers.
package rf_writeback_arbiter_pkg;

    localparam int RF_AW = 5;
    localparam int RF_DW = 32;
    localparam int RF_N  = 3;

    localparam int NREG = 2 ** RF_AW;

    localparam logic [RF_AW-1:0] X0_ADDR = '0;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_CSR = 2;

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter with registered priority pointer.
// The grant is combinational from req_i and never depends on a ready.
module rr_arbiter #(
    parameter int N = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] gnt_idx_o,
    output logic          gnt_any_o
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    int            cand;

    // First requester at or after the pointer, wrapping at N-1.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        cand      = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!gnt_any_o && req_i[cand]) begin
                gnt_any_o   = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = PW'(cand);
            end
        end
    end

    // Winner moves to lowest priority; pointer holds when idle.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any_o) begin
            if (gnt_idx_o == PW'(N - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx_o + 1'b1;
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Shares the register-file write port among writeback units
// and tracks pending destination registers for decode hazards.
module rf_writeback_arbiter
    import rf_writeback_arbiter_pkg::*;
#(
    parameter int N  = RF_N,
    parameter int AW = RF_AW,
    parameter int DW = RF_DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [N*AW-1:0]   req_waddr,
    input  logic [N*DW-1:0]   req_wdata,
    output logic              rf_wen,
    output logic [AW-1:0]     rf_waddr,
    output logic [DW-1:0]     rf_wdata,
    input  logic              rsv_valid,
    input  logic [AW-1:0]     rsv_addr,
    output logic              rsv_ok,
    input  logic [AW-1:0]     chk_addr1,
    input  logic [AW-1:0]     chk_addr2,
    output logic              hazard1,
    output logic              hazard2,
    output logic [2**AW-1:0]  busy_vec
);

    localparam int NR = 2 ** AW;
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  gnt;
    logic [PW-1:0] gnt_idx;
    logic          hs;
    logic [NR-1:0] busy_q;
    logic [NR-1:0] busy_d;

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_valid),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_any_o (hs)
    );

    assign req_ready = gnt;

    // Steer the granted requester onto the write port; x0 never writes.
    always_comb begin
        rf_waddr = '0;
        rf_wdata = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                rf_waddr = req_waddr[i*AW +: AW];
                rf_wdata = req_wdata[i*DW +: DW];
            end
        end
        rf_wen = hs && (rf_waddr != AW'(0));
    end

    assign rsv_ok = (rsv_addr == AW'(0)) || !busy_q[rsv_addr];

    // Clear on writeback first, then set on reservation, so a
    // same-cycle reserve of the written register stays pending.
    always_comb begin
        busy_d = busy_q;
        if (hs && rf_waddr != AW'(0)) begin
            busy_d[rf_waddr] = 1'b0;
        end
        if (rsv_valid && rsv_ok && rsv_addr != AW'(0)) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign hazard1  = busy_q[chk_addr1];
    assign hazard2  = busy_q[chk_addr2];
    assign busy_vec = busy_q;

    logic unused_idx;
    assign unused_idx = ^gnt_idx;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed-vector bench for rf_writeback_arbiter.
// Inputs change at negedge; outputs are sampled 1ns later.
module tb_rf_writeback_arbiter;
    import rf_writeback_arbiter_pkg::*;

    localparam int N  = RF_N;
    localparam int AW = RF_AW;
    localparam int DW = RF_DW;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_waddr;
    logic [N*DW-1:0]   req_wdata;
    logic              rf_wen;
    logic [AW-1:0]     rf_waddr;
    logic [DW-1:0]     rf_wdata;
    logic              rsv_valid;
    logic [AW-1:0]     rsv_addr;
    logic              rsv_ok;
    logic [AW-1:0]     chk_addr1;
    logic [AW-1:0]     chk_addr2;
    logic              hazard1;
    logic              hazard2;
    logic [NREG-1:0]   busy_vec;

    int n_vec;
    int n_err;

    rf_writeback_arbiter #(
        .N  (N),
        .AW (AW),
        .DW (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_waddr (req_waddr),
        .req_wdata (req_wdata),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_ok    (rsv_ok),
        .chk_addr1 (chk_addr1),
        .chk_addr2 (chk_addr2),
        .hazard1   (hazard1),
        .hazard2   (hazard2),
        .busy_vec  (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_eq(input string tag,
                             input logic [63:0] got,
                             input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_waddr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    logic [N-1:0]    exp_gnt [6];
    logic [AW-1:0]   exp_wa  [6];

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_waddr = '0;
        req_wdata = '0;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        chk_addr1 = '0;
        chk_addr2 = '0;

        // Reset, idle inputs.
        step();
        expect_eq("rst_busy", 64'(busy_vec), 64'h0);
        expect_eq("rst_wen", 64'(rf_wen), 64'h0);
        expect_eq("rst_ready", 64'(req_ready), 64'h0);
        expect_eq("rst_haz1", 64'(hazard1), 64'h0);
        rst = 1'b0;
        step();

        // Round robin among all three.
        exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        exp_wa  = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
        set_req(REQ_ALU, 5'd1, 32'hA000_0001);
        set_req(REQ_LSU, 5'd2, 32'hB000_0002);
        set_req(REQ_CSR, 5'd3, 32'hC000_0003);
        req_valid = 3'b111;
        #1;
        for (int c = 0; c < 6; c++) begin
            expect_eq($sformatf("rr_gnt%0d", c),
                      64'(req_ready), 64'(exp_gnt[c]));
            expect_eq($sformatf("rr_wa%0d", c),
                      64'(rf_waddr), 64'(exp_wa[c]));
            expect_eq($sformatf("rr_wen%0d", c), 64'(rf_wen), 64'h1);
            step();
        end
        expect_eq("rr_wd_last", 64'(rf_wdata), 64'hA000_0001);
        req_valid = '0;

        // Reserve x5, hazard, WAW reject, LSU writeback clears.
        rsv_valid = 1'b1;
        rsv_addr  = 5'd5;
        #1;
        expect_eq("rsv5_ok", 64'(rsv_ok), 64'h1);
        step();
        rsv_valid = 1'b0;
        chk_addr1 = 5'd5;
        #1;
        expect_eq("haz1_x5", 64'(hazard1), 64'h1);
        expect_eq("busy_x5", 64'(busy_vec), 64'h20);
        rsv_valid = 1'b1;
        #1;
        expect_eq("rsv5_waw", 64'(rsv_ok), 64'h0);
        step();
        rsv_valid = 1'b0;
        set_req(REQ_LSU, 5'd5, 32'hDEAD_BEEF);
        req_valid = 3'b010;
        #1;
        expect_eq("lsu_gnt", 64'(req_ready), 64'h2);
        expect_eq("lsu_wen", 64'(rf_wen), 64'h1);
        expect_eq("lsu_wa", 64'(rf_waddr), 64'h5);
        expect_eq("lsu_wd", 64'(rf_wdata), 64'hDEAD_BEEF);
        expect_eq("lsu_haz_hold", 64'(hazard1), 64'h1);
        step();
        req_valid = '0;
        #1;
        expect_eq("lsu_haz_clr", 64'(hazard1), 64'h0);
        expect_eq("lsu_busy_clr", 64'(busy_vec), 64'h0);

        // Same-cycle reserve and writeback of x7 (ptr=2, ALU wins).
        set_req(REQ_ALU, 5'd7, 32'h0000_0777);
        req_valid = 3'b001;
        rsv_valid = 1'b1;
        rsv_addr  = 5'd7;
        #1;
        expect_eq("x7_gnt", 64'(req_ready), 64'h1);
        expect_eq("x7_rsv_ok", 64'(rsv_ok), 64'h1);
        step();
        req_valid = '0;
        rsv_valid = 1'b0;
        #1;
        expect_eq("x7_busy", 64'(busy_vec), 64'h80);

        // Write to x0 (ptr=1), reserve x0, check x0.
        set_req(REQ_LSU, 5'd0, 32'h0000_1234);
        req_valid = 3'b010;
        rsv_valid = 1'b1;
        rsv_addr  = 5'd0;
        chk_addr2 = 5'd0;
        #1;
        expect_eq("x0_ready", 64'(req_ready), 64'h2);
        expect_eq("x0_wen", 64'(rf_wen), 64'h0);
        expect_eq("x0_rsv_ok", 64'(rsv_ok), 64'h1);
        expect_eq("x0_haz2", 64'(hazard2), 64'h0);
        step();
        req_valid = '0;
        rsv_valid = 1'b0;
        #1;
        expect_eq("x0_busy", 64'(busy_vec), 64'h80);

        // ptr=2: CSR grant wraps ptr to 0.
        set_req(REQ_CSR, 5'd9, 32'h0000_0009);
        req_valid = 3'b100;
        #1;
        expect_eq("csr_gnt_a", 64'(req_ready), 64'h4);
        step();
        // ptr=0, only CSR valid: granted immediately, ptr wraps to 0.
        #1;
        expect_eq("csr_gnt_b", 64'(req_ready), 64'h4);
        expect_eq("csr_wa", 64'(rf_waddr), 64'h9);
        step();
        set_req(REQ_ALU, 5'd10, 32'h0000_000A);
        req_valid = 3'b101;
        #1;
        expect_eq("wrap_alu", 64'(req_ready), 64'h1);
        expect_eq("wrap_wa", 64'(rf_waddr), 64'hA);
        step();

        // Async reset mid-cycle with x7 pending.
        req_valid = '0;
        chk_addr1 = 5'd7;
        #1;
        expect_eq("pre_rst_haz", 64'(hazard1), 64'h1);
        #2;
        rst = 1'b1;
        #1;
        expect_eq("arst_busy", 64'(busy_vec), 64'h0);
        expect_eq("arst_haz1", 64'(hazard1), 64'h0);
        expect_eq("arst_ready", 64'(req_ready), 64'h0);
        expect_eq("arst_wen", 64'(rf_wen), 64'h0);
        step();
        rst = 1'b0;
        step();
        // ptr was 1 before reset; after reset ALU must win.
        set_req(REQ_ALU, 5'd1, 32'h1);
        set_req(REQ_LSU, 5'd2, 32'h2);
        set_req(REQ_CSR, 5'd3, 32'h3);
        req_valid = 3'b111;
        #1;
        expect_eq("post_rst_gnt", 64'(req_ready), 64'h1);
        step();
        req_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
